// File: rtl/teeter_pkg.sv
// Shared definitions for the teeter physics sequencer: FSM states, wall-hit bit
// positions and the default beam geometry also used by the game/display logic.
package teeter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_TICK,
        ST_REQ,
        ST_WAIT_ACC,
        ST_CALC_V,
        ST_CALC_P,
        ST_BOUND
    } seq_state_e;

    localparam int HIT_MIN = 0;
    localparam int HIT_MAX = 1;

    localparam int DEF_TICK_DIV    = 50000;
    localparam int DEF_ACC_TIMEOUT = 64;
    localparam int DEF_POS_SHIFT   = 8;

    // Accumulator units carry DEF_POS_SHIFT fractional bits (640 px beam).
    localparam logic signed [31:0] DEF_POS_MIN  = 32'sd0;
    localparam logic signed [31:0] DEF_POS_MAX  = 32'sd163840;
    localparam logic signed [31:0] DEF_POS_INIT = 32'sd81920;

endpackage

// File: rtl/physics_tick_gen.sv
// Physics update tick: down-counter that pulses for one cycle at zero and reloads.
// Held at reload while disabled so a fresh enable always yields a full period.
module physics_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic CLK,
    input  logic i_rst,
    input  logic i_enable,
    output logic o_tick
);
    localparam int            CW     = $clog2(TICK_DIV);
    localparam logic [CW-1:0] RELOAD = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q - 1'b1;
        if (!i_enable || cnt_q == '0) cnt_d = RELOAD;
    end

    always_ff @(posedge CLK) begin
        if (i_rst) cnt_q <= RELOAD;
        else       cnt_q <= cnt_d;
    end

    assign o_tick = i_enable && (cnt_q == '0);

endmodule

// File: rtl/teeter_physics_sequencer.sv
// Per-tick physics step: sample tilt, strobe the velocity integrator, integrate
// velocity into the ball position and clamp it at the beam ends.
module teeter_physics_sequencer
    import teeter_pkg::*;
#(
    parameter int                 TICK_DIV    = DEF_TICK_DIV,
    parameter int                 ACC_TIMEOUT = DEF_ACC_TIMEOUT,
    parameter int                 POS_SHIFT   = DEF_POS_SHIFT,
    parameter logic signed [31:0] POS_MIN     = DEF_POS_MIN,
    parameter logic signed [31:0] POS_MAX     = DEF_POS_MAX,
    parameter logic signed [31:0] POS_INIT    = DEF_POS_INIT
) (
    input  logic               CLK,
    input  logic               i_rst,
    input  logic               i_enable,
    input  logic               i_restart,
    output logic               o_sample_req,
    input  logic               i_accel_valid,
    input  logic signed [7:0]  i_accel,
    output logic               o_calc_time,
    output logic signed [7:0]  o_accel,
    output logic               o_rst_v,
    input  logic signed [31:0] i_velocity,
    output logic signed [31:0] o_position,
    output logic               o_pos_valid,
    output logic [1:0]         o_hit_wall,
    output logic               o_sensor_err,
    output logic               o_overrun
);
    localparam int TW = $clog2(ACC_TIMEOUT + 1);

    seq_state_e         state_q, state_d;
    logic [TW-1:0]      tmo_q, tmo_d, tmo_inc;
    logic signed [7:0]  accel_q, accel_d;
    logic signed [31:0] acc_q, acc_d, acc_clamped, pos_q, pos_d;
    logic               pos_valid_q, pos_valid_d, rst_v_q, rst_v_d;
    logic [1:0]         hit_q, hit_d, hit_cmp;
    logic               err_q, err_d, ovr_q, ovr_d;
    logic               tick;

    physics_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .CLK      (CLK),
        .i_rst    (i_rst),
        .i_enable (i_enable),
        .o_tick   (tick)
    );

    // Landing exactly on a bound is legal and not reported as a hit.
    always_comb begin
        acc_clamped = acc_q;
        hit_cmp     = '0;
        if (acc_q < POS_MIN) begin
            acc_clamped      = POS_MIN;
            hit_cmp[HIT_MIN] = 1'b1;
        end else if (acc_q > POS_MAX) begin
            acc_clamped      = POS_MAX;
            hit_cmp[HIT_MAX] = 1'b1;
        end
    end

    assign tmo_inc = tmo_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        accel_d     = accel_q;
        acc_d       = acc_q;
        pos_d       = pos_q;
        pos_valid_d = 1'b0;
        rst_v_d     = 1'b0;
        hit_d       = '0;
        err_d       = err_q;
        ovr_d       = ovr_q | (tick && state_q != ST_WAIT_TICK);

        case (state_q)
            ST_IDLE:      if (i_enable) state_d = ST_WAIT_TICK;
            ST_WAIT_TICK: begin
                if (tick)           state_d = ST_REQ;
                else if (!i_enable) state_d = ST_IDLE;
            end
            ST_REQ: begin
                tmo_d   = '0;
                state_d = ST_WAIT_ACC;
            end
            ST_WAIT_ACC: begin
                tmo_d = tmo_inc;
                if (i_accel_valid) begin
                    accel_d = i_accel;
                    state_d = ST_CALC_V;
                end else if (tmo_inc == TW'(ACC_TIMEOUT)) begin
                    accel_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_CALC_V;
                end
            end
            ST_CALC_V: state_d = ST_CALC_P;
            ST_CALC_P: begin
                acc_d   = acc_q + i_velocity;
                state_d = ST_BOUND;
            end
            ST_BOUND: begin
                acc_d       = acc_clamped;
                pos_d       = acc_clamped >>> POS_SHIFT;
                pos_valid_d = 1'b1;
                hit_d       = hit_cmp;
                rst_v_d     = |hit_cmp;
                state_d     = i_enable ? ST_WAIT_TICK : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Restart aborts whatever is in flight and overrides a same-cycle wall hit.
        if (i_restart) begin
            state_d     = i_enable ? ST_WAIT_TICK : ST_IDLE;
            acc_d       = POS_INIT;
            pos_d       = POS_INIT >>> POS_SHIFT;
            pos_valid_d = 1'b1;
            rst_v_d     = 1'b1;
            hit_d       = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            tmo_q       <= '0;
            accel_q     <= '0;
            acc_q       <= POS_INIT;
            pos_q       <= POS_INIT >>> POS_SHIFT;
            pos_valid_q <= 1'b0;
            rst_v_q     <= 1'b0;
            hit_q       <= '0;
            err_q       <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            accel_q     <= accel_d;
            acc_q       <= acc_d;
            pos_q       <= pos_d;
            pos_valid_q <= pos_valid_d;
            rst_v_q     <= rst_v_d;
            hit_q       <= hit_d;
            err_q       <= err_d;
            ovr_q       <= ovr_d;
        end
    end

    assign o_sample_req = (state_q == ST_REQ);
    assign o_calc_time  = (state_q == ST_CALC_V);
    assign o_accel      = accel_q;
    assign o_position   = pos_q;
    assign o_pos_valid  = pos_valid_q;
    assign o_hit_wall   = hit_q;
    assign o_rst_v      = rst_v_q;
    assign o_sensor_err = err_q;
    assign o_overrun    = ovr_q;

endmodule

// File: tb/tb_teeter_physics_sequencer.sv
// Scoreboard bench: a sampler model answers each sample request, predicts the
// integrator strobe and the resulting position event; a monitor compares them.
module tb_teeter_physics_sequencer;
    localparam int TD    = 16;
    localparam int ATO   = 64;
    localparam int PMIN  = 0;
    localparam int PMAX  = 163840;
    localparam int PINIT = 81920;

    logic               CLK = 1'b0;
    logic               i_rst = 1'b1;
    logic               i_enable = 1'b0;
    logic               i_restart = 1'b0;
    logic               o_sample_req;
    logic               i_accel_valid = 1'b0;
    logic signed [7:0]  i_accel = '0;
    logic               o_calc_time;
    logic signed [7:0]  o_accel;
    logic               o_rst_v;
    logic signed [31:0] i_velocity = '0;
    logic signed [31:0] o_position;
    logic               o_pos_valid;
    logic [1:0]         o_hit_wall;
    logic               o_sensor_err;
    logic               o_overrun;

    teeter_physics_sequencer #(.TICK_DIV(TD), .ACC_TIMEOUT(ATO)) dut (
        .CLK(CLK), .i_rst(i_rst), .i_enable(i_enable), .i_restart(i_restart),
        .o_sample_req(o_sample_req), .i_accel_valid(i_accel_valid), .i_accel(i_accel),
        .o_calc_time(o_calc_time), .o_accel(o_accel), .o_rst_v(o_rst_v),
        .i_velocity(i_velocity), .o_position(o_position), .o_pos_valid(o_pos_valid),
        .o_hit_wall(o_hit_wall), .o_sensor_err(o_sensor_err), .o_overrun(o_overrun)
    );

    always #5 CLK = ~CLK;

    typedef struct { int k; bit tgt; int vel; int accel; bit noise; } plan_t;
    typedef struct { int cyc; int accel; } calc_t;
    typedef struct { int cyc; int pos; int hit; int rst; bit ovr; bit err; } pos_t;

    plan_t plan_q[$];
    calc_t calc_q[$];
    pos_t  pos_q[$];

    int n_chk = 0, n_fail = 0;
    int cyc = 0, valid_at = -1, last_r = 0, req_count = 0, seq_done = 0;
    int acc_model = PINIT, acc8 = 0;
    bit m_err = 0, m_ovr = 0, noise_now = 0, rst_seen = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge CLK) begin
        cyc      <= cyc + 1;
        rst_seen <= i_restart && !i_rst;
    end

    // Model, monitor and sampler responder.
    always @(negedge CLK) begin
        calc_t ce; pos_t pe; plan_t p;
        int keff, vel, hit, rst;
        if (i_rst) begin
            i_accel_valid = 1'b0;
            valid_at      = -1;
        end else begin
            if (rst_seen) begin
                while (calc_q.size() > 0 && calc_q[$].cyc >= cyc) ce = calc_q.pop_back();
                while (pos_q.size() > 0 && pos_q[$].cyc >= cyc) pe = pos_q.pop_back();
                acc_model = PINIT;
                valid_at  = -1;
                pos_q.push_back('{cyc, PINIT / 256, 0, 1, m_ovr, m_err});
            end
            if (calc_q.size() > 0 && calc_q[0].cyc < cyc) begin
                chk("calc_missing_at", cyc, calc_q[0].cyc);
                ce = calc_q.pop_front();
            end
            if (pos_q.size() > 0 && pos_q[0].cyc < cyc) begin
                chk("pos_valid_missing_at", cyc, pos_q[0].cyc);
                pe = pos_q.pop_front();
            end
            if (o_calc_time) begin
                chk("calc_expected", calc_q.size() > 0, 1);
                if (calc_q.size() > 0) begin
                    ce = calc_q.pop_front();
                    chk("calc_cycle", cyc, ce.cyc);
                    chk("calc_accel", o_accel, ce.accel);
                end
            end
            if (o_pos_valid) begin
                chk("pos_expected", pos_q.size() > 0, 1);
                if (pos_q.size() > 0) begin
                    pe = pos_q.pop_front();
                    chk("pos_cycle", cyc, pe.cyc);
                    chk("position", o_position, pe.pos);
                    chk("hit_wall", o_hit_wall, pe.hit);
                    chk("rst_v", o_rst_v, pe.rst);
                    chk("overrun", o_overrun, pe.ovr);
                    chk("sensor_err", o_sensor_err, pe.err);
                end
                seq_done++;
            end else begin
                chk("stray_hit_or_rst_v", {o_hit_wall, o_rst_v}, 0);
            end

            noise_now = 1'b0;
            if (o_sample_req) begin
                if (plan_q.size() > 0) p = plan_q.pop_front();
                else begin
                    p.k     = int'($urandom_range(14, 1));
                    p.tgt   = 1'b0;
                    p.vel   = int'($urandom_range(6000)) - 3000;
                    p.accel = int'($urandom_range(255)) - 128;
                    p.noise = 1'($urandom_range(1));
                end
                req_count++;
                last_r    = cyc;
                keff      = (p.k == 0) ? ATO : p.k;
                vel       = p.tgt ? p.vel - acc_model : p.vel;
                i_velocity = 32'(vel);
                if (p.k == 0) begin
                    m_err = 1'b1; acc8 = 0; valid_at = -1;
                end else begin
                    acc8 = p.accel; valid_at = cyc + p.k;
                end
                // The next tick lands TD cycles after the one that started this step.
                if (keff + 5 > TD) m_ovr = 1'b1;
                acc_model = acc_model + vel;
                hit = 0; rst = 0;
                if (acc_model < PMIN) begin acc_model = PMIN; hit = 1; rst = 1; end
                else if (acc_model > PMAX) begin acc_model = PMAX; hit = 2; rst = 1; end
                calc_q.push_back('{cyc + keff + 1, acc8});
                pos_q.push_back('{cyc + keff + 4, acc_model / 256, hit, rst, m_ovr, m_err});
                noise_now = p.noise;
            end
            i_accel_valid = (cyc == valid_at) || noise_now;
            i_accel       = (cyc == valid_at) ? 8'(acc8) : 8'($urandom);
        end
    end

    task automatic wait_seqs(input int n);
        int target = seq_done + n;
        int g = 0;
        while (seq_done < target && g < n * 200) begin @(negedge CLK); g++; end
        if (seq_done < target) chk("seq_timeout", seq_done, target);
    endtask

    task automatic wait_req(input int r0);
        int g = 0;
        while (req_count == r0 && g < 200) begin @(negedge CLK); g++; end
        if (req_count == r0) chk("req_timeout", req_count, r0 + 1);
    endtask

    task automatic wait_cyc(input int t);
        int g = 0;
        while (cyc < t && g < 1000) begin @(negedge CLK); g++; end
    endtask

    initial begin
        int r0;
        repeat (3) @(negedge CLK);
        chk("reset_position", o_position, PINIT / 256);
        chk("reset_accel", o_accel, 0);
        chk("reset_sensor_err", o_sensor_err, 0);
        chk("reset_overrun", o_overrun, 0);
        chk("reset_pulses", {o_sample_req, o_calc_time, o_pos_valid, o_rst_v, o_hit_wall}, 0);
        i_rst    = 1'b0;
        i_enable = 1'b1;

        repeat (3) plan_q.push_back('{2, 1'b0, 256, 10, 1'b0});
        wait_seqs(3);
        chk("no_overrun_yet", o_overrun, 0);

        plan_q.push_back('{20, 1'b0, 100, -7, 1'b1});
        wait_seqs(1);
        chk("overrun_sticky", o_overrun, 1);

        plan_q.push_back('{0, 1'b0, -300, 0, 1'b0});
        wait_seqs(1);
        chk("sensor_err_sticky", o_sensor_err, 1);

        plan_q.push_back('{2, 1'b1, 163800, 5, 1'b0});
        plan_q.push_back('{2, 1'b0, 512, 6, 1'b0});
        plan_q.push_back('{2, 1'b0, 0, 7, 1'b0});
        plan_q.push_back('{3, 1'b1, 0, -8, 1'b1});
        plan_q.push_back('{2, 1'b0, -5000, 9, 1'b0});
        wait_seqs(5);

        plan_q.push_back('{8, 1'b0, 4000, 33, 1'b0});
        r0 = req_count;
        wait_req(r0);
        wait_cyc(last_r + 3);
        i_restart = 1'b1;
        @(negedge CLK);
        i_restart = 1'b0;
        wait_seqs(1);
        wait_seqs(2);

        plan_q.push_back('{2, 1'b0, 700, 12, 1'b0});
        r0 = req_count;
        wait_req(r0);
        wait_cyc(last_r + 4);
        i_enable = 1'b0;
        wait_seqs(1);
        r0 = req_count;
        repeat (3 * TD) @(negedge CLK);
        chk("no_req_while_disabled", req_count - r0, 0);
        i_enable = 1'b1;

        wait_seqs(15);
        repeat (5) @(negedge CLK);
        chk("calc_queue_drained", calc_q.size(), 0);
        chk("pos_queue_drained", pos_q.size(), 0);
        chk("sensor_err_final", o_sensor_err, 1);
        chk("overrun_final", o_overrun, 1);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
